square_wave_gen: RTL and testbench

SQUARE_WAVE_GEN -- requirements
Module: square_wave_gen

---
 rtl/square_wave_pkg.sv | 16 +
 rtl/lock_settle.sv | 29 ++
 rtl/square_wave_gen.sv | 104 ++++++++++
 tb/tb_square_wave_gen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/square_wave_pkg.sv
// Shared definitions for the square-wave generator: FSM state encoding and
// configuration defaults applied at reset.
package square_wave_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RUN
    } state_t;

    // 1 MHz, 50% duty at a 100 MHz generator clock
    localparam int unsigned DEF_PERIOD = 100;
    localparam int unsigned DEF_HIGH   = 50;
    localparam int unsigned MIN_PERIOD = 2;

endpackage

// File: rtl/lock_settle.sv
// Counts consecutive cycles of PLL lock; settled flags the cycle on which the
// run of lock cycles reaches LOCK_SETTLE.
module lock_settle #(
    parameter int unsigned LOCK_SETTLE = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic lock,
    output logic settled
);

    localparam int unsigned SW = $clog2(LOCK_SETTLE + 1);
    localparam logic [SW-1:0] LAST = SW'(LOCK_SETTLE - 1);

    logic [SW-1:0] count;

    // Combinational so the FSM can leave SETTLE on the LOCK_SETTLE-th lock cycle
    assign settled = lock && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear || !lock) begin
            count <= '0;
        end else if (!settled) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/square_wave_gen.sv
// Programmable square-wave generator gated by PLL lock, with shadowed
// period/high-time configuration applied only on period boundaries.
module square_wave_gen
    import square_wave_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned LOCK_SETTLE = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pll_lock,
    input  logic             enable,
    input  logic             load,
    input  logic [CNT_W-1:0] period_in,
    input  logic [CNT_W-1:0] high_in,
    output logic             wave,
    output logic             period_start,
    output logic             running,
    output logic             cfg_pending
);

    localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] RST_HIGH   = CNT_W'(DEF_HIGH);
    localparam logic [CNT_W-1:0] MIN_P      = CNT_W'(MIN_PERIOD);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_a;
    logic [CNT_W-1:0] high_a;
    logic [CNT_W-1:0] period_s;
    logic [CNT_W-1:0] high_s;
    logic [CNT_W-1:0] period_cap;
    logic             settled;
    logic             settle_clear;
    logic             stay_run;
    logic             period_end;
    logic             apply;

    always_comb begin
        period_cap   = (period_in < MIN_P) ? MIN_P : period_in;
        stay_run     = (state == RUN) && enable && pll_lock;
        period_end   = (cnt >= period_a - 1'b1);
        apply        = (state != RUN) || period_end;
        settle_clear = (state != SETTLE) || !enable;

        next_state = state;
        if (!enable) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    next_state = SETTLE;
                SETTLE:  if (settled) next_state = RUN;
                RUN:     if (!pll_lock) next_state = SETTLE;
                default: next_state = IDLE;
            endcase
        end
    end

    lock_settle #(
        .LOCK_SETTLE(LOCK_SETTLE)
    ) u_lock_settle (
        .clk    (clk),
        .reset  (reset),
        .clear  (settle_clear),
        .lock   (pll_lock),
        .settled(settled)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            wave         <= 1'b0;
            period_start <= 1'b0;
            running      <= 1'b0;
            cfg_pending  <= 1'b0;
            period_a     <= RST_PERIOD;
            high_a       <= RST_HIGH;
            period_s     <= RST_PERIOD;
            high_s       <= RST_HIGH;
        end else begin
            state        <= next_state;
            running      <= (next_state == RUN);
            wave         <= stay_run && (cnt < high_a);
            period_start <= stay_run && (cnt == '0);
            cnt          <= (stay_run && !period_end) ? cnt + 1'b1 : '0;

            if (load) begin
                period_s <= period_cap;
                high_s   <= high_in;
            end
            // Shadow always mirrors active once applied, so an idle apply is a no-op
            if (apply) begin
                period_a    <= load ? period_cap : period_s;
                high_a      <= load ? high_in : high_s;
                cfg_pending <= 1'b0;
            end else if (load) begin
                cfg_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_square_wave_gen.sv
// Self-checking bench for square_wave_gen: segment table with analytically
// derived waveforms, expectations queued per cycle and checked after each edge.
module tb_square_wave_gen;

    localparam int unsigned W = 16;
    localparam int unsigned L = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         pll_lock;
    logic         enable;
    logic         load;
    logic [W-1:0] period_in;
    logic [W-1:0] high_in;
    logic         wave;
    logic         period_start;
    logic         running;
    logic         cfg_pending;

    always #5 clk = ~clk;

    square_wave_gen #(
        .CNT_W      (W),
        .LOCK_SETTLE(L)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pll_lock    (pll_lock),
        .enable      (enable),
        .load        (load),
        .period_in   (period_in),
        .high_in     (high_in),
        .wave        (wave),
        .period_start(period_start),
        .running     (running),
        .cfg_pending (cfg_pending)
    );

    typedef struct {
        string       name;
        bit          rst, en, lock, ld;
        int unsigned pin, hin, n;
        bit          er;
        int unsigned p, h, ph;
        bit          pend;
    } seg_t;

    typedef struct {
        string name;
        bit    w, ps, r, pend;
    } exp_t;

    seg_t segs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic seg_t mk(string name, bit rst, bit en, bit lock, bit ld,
                                int unsigned pin, int unsigned hin, int unsigned n,
                                bit er, int unsigned p, int unsigned h,
                                int unsigned ph, bit pend);
        seg_t s;
        s.name = name; s.rst = rst; s.en = en; s.lock = lock; s.ld = ld;
        s.pin = pin; s.hin = hin; s.n = n; s.er = er;
        s.p = p; s.h = h; s.ph = ph; s.pend = pend;
        return s;
    endfunction

    // p == 0: generator not producing (wave/period_start low, running = er);
    // otherwise running with output phase (ph + i) mod p.
    function automatic exp_t expect_of(seg_t s, int unsigned i);
        exp_t        e;
        int unsigned ph;
        e.name = s.name;
        e.pend = s.pend;
        if (s.p == 0) begin
            e.w = 1'b0; e.ps = 1'b0; e.r = s.er;
        end else begin
            ph   = (s.ph + i) % s.p;
            e.w  = (ph < s.h);
            e.ps = (ph == 0);
            e.r  = 1'b1;
        end
        return e;
    endfunction

    task automatic check(string name, string what, bit act, bit req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s: got %0b expected %0b at %0t", name, what, act, req, $time);
        end
    endtask

    task automatic step(bit rst, bit en, bit lock, bit ld, int unsigned pin,
                        int unsigned hin, exp_t e);
        exp_t x;
        reset     = rst;
        enable    = en;
        pll_lock  = lock;
        load      = ld;
        period_in = W'(pin);
        high_in   = W'(hin);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard: got empty queue expected entry for %s", e.name);
        end else begin
            x = sb.pop_front();
            check(x.name, "wave", wave, x.w);
            check(x.name, "period_start", period_start, x.ps);
            check(x.name, "running", running, x.r);
            check(x.name, "cfg_pending", cfg_pending, x.pend);
        end
    endtask

    task automatic run_seg(seg_t s);
        for (int unsigned i = 0; i < s.n; i++)
            step(s.rst, s.en, s.lock, s.ld && (i == 0), s.pin, s.hin, expect_of(s, i));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; pll_lock = 1'b0; load = 1'b0;
        period_in = '0; high_in = '0;

        //            name           rst en lk ld pin hin  n     er p    h   ph  pend
        segs.push_back(mk("reset",       1, 0, 0, 0, 0,  0,  2,    0, 0,   0,  0,  0));
        segs.push_back(mk("idle_load",   0, 0, 1, 1, 12, 4,  1,    0, 0,   0,  0,  0));
        segs.push_back(mk("reset2",      1, 0, 0, 0, 0,  0,  1,    0, 0,   0,  0,  0));
        segs.push_back(mk("settle",      0, 1, 1, 0, 0,  0,  L,    0, 0,   0,  0,  0));
        segs.push_back(mk("run_rise",    0, 1, 1, 0, 0,  0,  1,    1, 0,   0,  0,  0));
        segs.push_back(mk("def_wave",    0, 1, 1, 0, 0,  0,  200,  1, 100, 50, 0,  0));
        segs.push_back(mk("pre_load",    0, 1, 1, 0, 0,  0,  30,   1, 100, 50, 0,  0));
        segs.push_back(mk("load_10_3",   0, 1, 1, 1, 10, 3,  1,    1, 100, 50, 30, 1));
        segs.push_back(mk("old_period",  0, 1, 1, 0, 0,  0,  68,   1, 100, 50, 31, 1));
        segs.push_back(mk("boundary",    0, 1, 1, 0, 0,  0,  1,    1, 100, 50, 99, 0));
        segs.push_back(mk("wave_10_3",   0, 1, 1, 0, 0,  0,  30,   1, 10,  3,  0,  0));
        segs.push_back(mk("pre_ovr",     0, 1, 1, 0, 0,  0,  5,    1, 10,  3,  0,  0));
        segs.push_back(mk("load_a",      0, 1, 1, 1, 20, 20, 1,    1, 10,  3,  5,  1));
        segs.push_back(mk("load_b",      0, 1, 1, 1, 4,  1,  1,    1, 10,  3,  6,  1));
        segs.push_back(mk("pend_b",      0, 1, 1, 0, 0,  0,  2,    1, 10,  3,  7,  1));
        segs.push_back(mk("xfer_b",      0, 1, 1, 0, 0,  0,  1,    1, 10,  3,  9,  0));
        segs.push_back(mk("wave_4_1",    0, 1, 1, 0, 0,  0,  8,    1, 4,   1,  0,  0));
        segs.push_back(mk("pre_coinc",   0, 1, 1, 0, 0,  0,  3,    1, 4,   1,  0,  0));
        segs.push_back(mk("coinc_load",  0, 1, 1, 1, 6,  2,  1,    1, 4,   1,  3,  0));
        segs.push_back(mk("wave_6_2",    0, 1, 1, 0, 0,  0,  12,   1, 6,   2,  0,  0));
        segs.push_back(mk("pre_clamp",   0, 1, 1, 0, 0,  0,  5,    1, 6,   2,  0,  0));
        segs.push_back(mk("load_1_0",    0, 1, 1, 1, 1,  0,  1,    1, 6,   2,  5,  0));
        segs.push_back(mk("wave_2_0",    0, 1, 1, 0, 0,  0,  8,    1, 2,   0,  0,  0));
        segs.push_back(mk("pre_hi",      0, 1, 1, 0, 0,  0,  1,    1, 2,   0,  0,  0));
        segs.push_back(mk("load_4_5",    0, 1, 1, 1, 4,  5,  1,    1, 2,   0,  1,  0));
        segs.push_back(mk("wave_4_5",    0, 1, 1, 0, 0,  0,  12,   1, 4,   5,  0,  0));
        segs.push_back(mk("pre_unlock",  0, 1, 1, 0, 0,  0,  2,    1, 4,   5,  0,  0));
        segs.push_back(mk("unlock",      0, 1, 0, 0, 0,  0,  1,    0, 0,   0,  0,  0));
        segs.push_back(mk("relock",      0, 1, 1, 0, 0,  0,  L-1,  0, 0,   0,  0,  0));
        segs.push_back(mk("relock_rise", 0, 1, 1, 0, 0,  0,  1,    1, 0,   0,  0,  0));
        segs.push_back(mk("resume",      0, 1, 1, 0, 0,  0,  8,    1, 4,   5,  0,  0));
        segs.push_back(mk("disable",     0, 0, 1, 0, 0,  0,  1,    0, 0,   0,  0,  0));
        segs.push_back(mk("en_settle",   0, 1, 1, 0, 0,  0,  4,    0, 0,   0,  0,  0));
        segs.push_back(mk("lock_glitch", 0, 1, 0, 0, 0,  0,  1,    0, 0,   0,  0,  0));
        segs.push_back(mk("partial",     0, 1, 1, 0, 0,  0,  5,    0, 0,   0,  0,  0));
        segs.push_back(mk("dis_settle",  0, 0, 1, 0, 0,  0,  1,    0, 0,   0,  0,  0));
        segs.push_back(mk("resettle",    0, 1, 1, 0, 0,  0,  L,    0, 0,   0,  0,  0));
        segs.push_back(mk("rise2",       0, 1, 1, 0, 0,  0,  1,    1, 0,   0,  0,  0));
        segs.push_back(mk("pre_rst",     0, 1, 1, 0, 0,  0,  6,    1, 4,   5,  0,  0));

        foreach (segs[k]) run_seg(segs[k]);

        // Reset mid-period with a coincident load: reset wins, config returns to 100/50.
        begin
            exp_t zero;
            zero.name = "rst_load"; zero.w = 1'b0; zero.ps = 1'b0; zero.r = 1'b0; zero.pend = 1'b0;
            step(1, 1, 1, 1, 9, 9, zero);
            zero.name = "post_rst_settle";
            for (int unsigned i = 0; i < L; i++) step(0, 1, 1, 0, 0, 0, zero);
            zero.name = "post_rst_rise"; zero.r = 1'b1;
            step(0, 1, 1, 0, 0, 0, zero);
            run_seg(mk("post_rst_wave", 0, 1, 1, 0, 0, 0, 100, 1, 100, 50, 0, 0));
        end

        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
